// File: rtl/ps2_kb_command_sequencer_if.sv
// Signal bundle between the PS/2 command sequencer and its surroundings:
// line drivers, receive-path handshake, command requests and status.
interface ps2_kb_command_sequencer_if;
  logic       device_clock;
  logic       device_data;
  logic       device_clock_oe;
  logic       device_data_oe;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       reset_req;
  logic       led_req;
  logic [2:0] led_value;
  logic       busy;
  logic       rx_mask;
  logic       cmd_done;
  logic       cmd_error;

  modport master (
    input  device_clock, device_data, rx_valid, rx_byte,
           reset_req, led_req, led_value,
    output device_clock_oe, device_data_oe, busy, rx_mask,
           cmd_done, cmd_error
  );

  modport slave (
    output device_clock, device_data, rx_valid, rx_byte,
           reset_req, led_req, led_value,
    input  device_clock_oe, device_data_oe, busy, rx_mask,
           cmd_done, cmd_error
  );
endinterface

// File: rtl/ps2_kb_command_sequencer.sv
// Host-to-device PS/2 keyboard command sequencer: arbitrates keyboard reset
// and LED update requests, serialises each byte and handles ACK/resend/timeout.
module ps2_kb_command_sequencer #(
  parameter logic [15:0] inhibit_cycles = 16'd5000,
  parameter logic [19:0] timeout_cycles = 20'd750000,
  parameter logic [1:0]  max_retry      = 2'd3
) (
  input  logic                               clock,
  input  logic                               reset,
  ps2_kb_command_sequencer_if.master         bus
);

  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, LINE_ACK, WAIT_RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev;
  logic        fe;

  logic        pend_rst, pend_rst_next;
  logic        pend_led, pend_led_next;
  logic [2:0]  led_latch, led_latch_next;
  logic        cmd_led, cmd_led_next;
  logic        byte_idx, byte_idx_next;
  logic [2:0]  led_byte, led_byte_next;
  logic [3:0]  bit_idx, bit_idx_next;
  logic [1:0]  retry_cnt, retry_cnt_next;
  logic [15:0] inhibit_cnt, inhibit_cnt_next;
  logic [19:0] wd_cnt, wd_cnt_next;
  logic        clock_oe, clock_oe_next;
  logic        data_oe, data_oe_next;
  logic        done_q, done_next;
  logic        error_q, error_next;
  logic        retry_evt;
  logic [7:0]  tx_byte;
  logic        frame_bit;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.device_clock};
      data_sync <= {data_sync[0], bus.device_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fe = clk_prev & ~clk_sync[1];

  always_comb begin
    tx_byte = cmd_led ? (byte_idx ? {5'b00000, led_byte} : 8'hED) : 8'hFF;
    case (bit_idx)
      4'd8:    frame_bit = ~^tx_byte;
      4'd9:    frame_bit = 1'b1;
      default: frame_bit = tx_byte[bit_idx[2:0]];
    endcase
  end

  always_comb begin
    state_next       = state;
    pend_rst_next    = pend_rst;
    pend_led_next    = pend_led;
    led_latch_next   = led_latch;
    cmd_led_next     = cmd_led;
    byte_idx_next    = byte_idx;
    led_byte_next    = led_byte;
    bit_idx_next     = bit_idx;
    retry_cnt_next   = retry_cnt;
    inhibit_cnt_next = inhibit_cnt;
    clock_oe_next    = clock_oe;
    data_oe_next     = data_oe;
    done_next        = 1'b0;
    error_next       = 1'b0;
    retry_evt        = 1'b0;

    case (state)
      IDLE: begin
        if (pend_rst || pend_led) begin
          state_next       = INHIBIT;
          cmd_led_next     = !pend_rst;
          pend_rst_next    = 1'b0;
          pend_led_next    = pend_led && pend_rst;
          byte_idx_next    = 1'b0;
          retry_cnt_next   = 2'd0;
          inhibit_cnt_next = 16'd0;
          clock_oe_next    = 1'b1;
          data_oe_next     = 1'b0;
        end
      end
      INHIBIT: begin
        if (inhibit_cnt == inhibit_cycles - 16'd1) begin
          state_next    = SEND;
          clock_oe_next = 1'b0;
          data_oe_next  = 1'b1;
          bit_idx_next  = 4'd0;
        end else begin
          inhibit_cnt_next = inhibit_cnt + 16'd1;
        end
      end
      SEND: begin
        if (fe) begin
          data_oe_next = ~frame_bit;
          if (bit_idx == 4'd9) state_next = LINE_ACK;
          else                 bit_idx_next = bit_idx + 4'd1;
        end
      end
      LINE_ACK: begin
        if (fe) begin
          if (!data_sync[1]) state_next = WAIT_RESP;
          else               retry_evt  = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == 8'hFA) begin
            retry_cnt_next = 2'd0;
            if (cmd_led && !byte_idx) begin
              // The LED byte is frozen here; later led_req only re-arm pend_led.
              byte_idx_next    = 1'b1;
              led_byte_next    = led_latch;
              state_next       = INHIBIT;
              inhibit_cnt_next = 16'd0;
              clock_oe_next    = 1'b1;
            end else begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end else if (bus.rx_byte == 8'hFE) begin
            retry_evt = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if ((state == SEND || state == LINE_ACK || state == WAIT_RESP) &&
        wd_cnt == timeout_cycles - 20'd1 && !fe && !bus.rx_valid)
      retry_evt = 1'b1;

    if (retry_evt) begin
      clock_oe_next = 1'b0;
      data_oe_next  = 1'b0;
      if (retry_cnt == max_retry) begin
        error_next = 1'b1;
        state_next = IDLE;
      end else begin
        retry_cnt_next   = retry_cnt + 2'd1;
        state_next       = INHIBIT;
        inhibit_cnt_next = 16'd0;
        clock_oe_next    = 1'b1;
      end
    end

    // Requests are accepted in every state and win over the clear on leaving IDLE.
    if (bus.reset_req) pend_rst_next = 1'b1;
    if (bus.led_req) begin
      pend_led_next  = 1'b1;
      led_latch_next = bus.led_value;
    end

    if (state == IDLE || state_next != state || fe || bus.rx_valid)
      wd_cnt_next = 20'd0;
    else
      wd_cnt_next = wd_cnt + 20'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pend_rst    <= 1'b0;
      pend_led    <= 1'b0;
      led_latch   <= 3'd0;
      cmd_led     <= 1'b0;
      byte_idx    <= 1'b0;
      led_byte    <= 3'd0;
      bit_idx     <= 4'd0;
      retry_cnt   <= 2'd0;
      inhibit_cnt <= 16'd0;
      wd_cnt      <= 20'd0;
      clock_oe    <= 1'b0;
      data_oe     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state       <= state_next;
      pend_rst    <= pend_rst_next;
      pend_led    <= pend_led_next;
      led_latch   <= led_latch_next;
      cmd_led     <= cmd_led_next;
      byte_idx    <= byte_idx_next;
      led_byte    <= led_byte_next;
      bit_idx     <= bit_idx_next;
      retry_cnt   <= retry_cnt_next;
      inhibit_cnt <= inhibit_cnt_next;
      wd_cnt      <= wd_cnt_next;
      clock_oe    <= clock_oe_next;
      data_oe     <= data_oe_next;
      done_q      <= done_next;
      error_q     <= error_next;
    end
  end

  assign bus.device_clock_oe = clock_oe;
  assign bus.device_data_oe  = data_oe;
  assign bus.busy            = (state != IDLE);
  assign bus.rx_mask         = (state != IDLE);
  assign bus.cmd_done        = done_q;
  assign bus.cmd_error       = error_q;

endmodule

// File: tb/tb_ps2_kb_command_sequencer.sv
// Self-checking bench: an emulated PS/2 keyboard answers each host frame from a
// response plan, and a transaction-level model predicts wire bytes and outcomes.
module tb_ps2_kb_command_sequencer;
  localparam logic [15:0] INHIBIT = 16'd24;
  localparam logic [19:0] TIMEOUT = 20'd400;
  localparam int          HALF    = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ps2_kb_command_sequencer_if bus();

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  assign bus.device_clock = ~(bus.device_clock_oe | dev_clk_low);
  assign bus.device_data  = ~(bus.device_data_oe | dev_data_low);

  ps2_kb_command_sequencer #(
    .inhibit_cycles(INHIBIT),
    .timeout_cycles(TIMEOUT),
    .max_retry(2'd3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic oddParity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0);
  endfunction

  // Response modes: 0 ACK+FA, 1 ACK+FE, 2 line NACK, 3 no clocks at all,
  // 4 ACK then silence, 5 ACK+junk+FA, 6 ACK+FA followed by AA.
  int         dev_plan[$];
  logic [7:0] wire_q[$];
  logic       wire_par_q[$];
  logic       wire_stop_q[$];
  int         start_count   = 0;
  int         dev_bit_count = 0;

  task automatic sendRx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  initial begin : device
    logic       prev, cur;
    logic [9:0] bits;
    logic [7:0] junk;
    int         mode;
    prev = 1'b0;
    bits = '0;
    forever begin
      @(negedge clock);
      cur = bus.device_clock_oe;
      if (prev && !cur && bus.device_data_oe === 1'b1 && reset) begin
        start_count++;
        mode = (dev_plan.size() > 0) ? dev_plan.pop_front() : 0;
        dev_bit_count = 0;
        if (mode != 3) begin
          repeat (6) @(negedge clock);
          for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            dev_bit_count++;
            repeat (HALF) @(negedge clock);
            bits[k] = bus.device_data;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clock);
          end
          wire_q.push_back(bits[7:0]);
          wire_par_q.push_back(bits[8]);
          wire_stop_q.push_back(bits[9]);
          if (mode != 2) dev_data_low = 1'b1;
          repeat (2) @(negedge clock);
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clock);
          dev_clk_low  = 1'b0;
          dev_data_low = 1'b0;
          repeat (HALF) @(negedge clock);
          case (mode)
            0: sendRx(8'hFA);
            1: sendRx(8'hFE);
            5: begin
              junk = 8'($urandom_range(0, 255));
              if (junk == 8'hFA || junk == 8'hFE) junk = 8'h55;
              sendRx(junk);
              repeat (4) @(negedge clock);
              sendRx(8'hFA);
            end
            6: begin
              sendRx(8'hFA);
              repeat (3) @(negedge clock);
              sendRx(8'hAA);
            end
            default: ;
          endcase
        end
        cur = bus.device_clock_oe;
      end
      prev = cur;
    end
  end

  int   done_count = 0, err_count = 0, busy_falls = 0, inh_run = 0;
  logic prev_busy = 1'b0, prev_cloe = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      inh_run   = 0;
      prev_busy = 1'b0;
      prev_cloe = 1'b0;
    end else begin
      checkOutput("rx_mask_vs_busy", bus.rx_mask, bus.busy);
      checkOutput("no_done_and_error", bus.cmd_done & bus.cmd_error, 1'b0);
      if (!bus.busy) begin
        checkOutput("idle_clock_oe", bus.device_clock_oe, 1'b0);
        checkOutput("idle_data_oe", bus.device_data_oe, 1'b0);
      end
      if (bus.cmd_done || bus.cmd_error) begin
        checkOutput("pulse_busy_low", bus.busy, 1'b0);
        checkOutput("pulse_follows_busy", prev_busy, 1'b1);
      end
      if (bus.cmd_done)  done_count++;
      if (bus.cmd_error) err_count++;
      if (prev_busy && !bus.busy) busy_falls++;
      if (bus.device_clock_oe) inh_run++;
      else if (prev_cloe) begin
        checkOutput("inhibit_length", inh_run, INHIBIT);
        checkOutput("start_bit_low", bus.device_data_oe, 1'b1);
        inh_run = 0;
      end
      prev_busy = bus.busy;
      prev_cloe = bus.device_clock_oe;
    end
  end

  int         base_done, base_err, base_falls, base_start;
  logic [7:0] exp_wire[$];

  task automatic beginTxn();
    base_done  = done_count;
    base_err   = err_count;
    base_falls = busy_falls;
    base_start = start_count;
    exp_wire.delete();
    wire_q.delete();
    wire_par_q.delete();
    wire_stop_q.delete();
  endtask

  task automatic applyStimulus(input logic rst_req, input logic l_req, input logic [2:0] val);
    @(negedge clock);
    bus.reset_req = rst_req;
    bus.led_req   = l_req;
    bus.led_value = val;
    @(negedge clock);
    bus.reset_req = 1'b0;
    bus.led_req   = 1'b0;
  endtask

  task automatic endTxn(input string tag, input int exp_done, input int exp_err);
    int n = 0;
    int m;
    while (((done_count - base_done) + (err_count - base_err) < exp_done + exp_err || bus.busy)
           && n < 8000) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, " completes_in_budget"}, n < 8000, 1'b1);
    repeat (40) @(negedge clock);
    checkOutput({tag, " cmd_done_count"}, done_count - base_done, exp_done);
    checkOutput({tag, " cmd_error_count"}, err_count - base_err, exp_err);
    checkOutput({tag, " busy_periods"}, busy_falls - base_falls, exp_done + exp_err);
    checkOutput({tag, " wire_byte_count"}, wire_q.size(), exp_wire.size());
    m = (wire_q.size() < exp_wire.size()) ? wire_q.size() : exp_wire.size();
    for (int i = 0; i < m; i++) begin
      checkOutput({tag, " wire_byte"}, wire_q[i], exp_wire[i]);
      checkOutput({tag, " wire_parity"}, wire_par_q[i], oddParity(exp_wire[i]));
      checkOutput({tag, " wire_stop"}, wire_stop_q[i], 1'b1);
    end
    checkOutput({tag, " plan_consumed"}, dev_plan.size(), 0);
  endtask

  // Builds one command's response plan and its expected wire bytes and outcome.
  task automatic planRandom(input logic is_led, input logic [2:0] val, output logic ok);
    logic [7:0] seq[$];
    int attempts, r, mode;
    ok = 1'b1;
    seq.delete();
    if (is_led) begin seq.push_back(8'hED); seq.push_back({5'b00000, val}); end
    else        seq.push_back(8'hFF);
    foreach (seq[b]) begin
      if (ok) begin
        attempts = 0;
        forever begin
          r = $urandom_range(0, 9);
          mode = (r <= 4) ? 0 : (r == 5) ? 5 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 4 : 3;
          dev_plan.push_back(mode);
          attempts++;
          if (mode != 3) exp_wire.push_back(seq[b]);
          if (mode == 0 || mode == 5) break;
          if (attempts == 4) begin ok = 1'b0; break; end
        end
      end
    end
  endtask

  initial begin : stimulus
    logic       ok;
    logic       is_led;
    logic [2:0] val;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.reset_req = 1'b0;
    bus.led_req   = 1'b0;
    bus.led_value = 3'd0;

    repeat (3) @(negedge clock);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset rx_mask", bus.rx_mask, 1'b0);
    checkOutput("reset clock_oe", bus.device_clock_oe, 1'b0);
    checkOutput("reset data_oe", bus.device_data_oe, 1'b0);
    checkOutput("reset cmd_done", bus.cmd_done, 1'b0);
    checkOutput("reset cmd_error", bus.cmd_error, 1'b0);
    #2 reset = 1'b1;
    repeat (5) @(negedge clock);

    $display("[TB] LED update 3'b100");
    beginTxn();
    dev_plan = '{0, 0};
    exp_wire = '{8'hED, 8'h04};
    applyStimulus(1'b0, 1'b1, 3'b100);
    endTxn("led", 1, 0);
    if (wire_par_q.size() == 2) begin
      checkOutput("ED parity literal", wire_par_q[0], 1'b1);
      checkOutput("04 parity literal", wire_par_q[1], 1'b0);
    end

    $display("[TB] Keyboard reset, AA after FA");
    beginTxn();
    dev_plan = '{6};
    exp_wire = '{8'hFF};
    applyStimulus(1'b1, 1'b0, 3'd0);
    endTxn("kbreset", 1, 0);
    if (wire_par_q.size() == 1) checkOutput("FF parity literal", wire_par_q[0], 1'b1);
    checkOutput("kbreset single frame", start_count - base_start, 1);

    $display("[TB] FE twice then FA");
    beginTxn();
    dev_plan = '{1, 1, 0, 0};
    exp_wire = '{8'hED, 8'hED, 8'hED, 8'h03};
    applyStimulus(1'b0, 1'b1, 3'b011);
    endTxn("resend", 1, 0);

    $display("[TB] Device silent after start bit");
    beginTxn();
    dev_plan = '{3, 3, 3, 3};
    applyStimulus(1'b0, 1'b1, 3'b101);
    endTxn("silent", 0, 1);
    checkOutput("silent start bits", start_count - base_start, 4);

    $display("[TB] Simultaneous reset_req and led_req");
    beginTxn();
    dev_plan = '{0, 0, 0};
    exp_wire = '{8'hFF, 8'hED, 8'h05};
    applyStimulus(1'b1, 1'b1, 3'b101);
    endTxn("priority", 2, 0);

    $display("[TB] Two led_req while busy");
    beginTxn();
    dev_plan = '{0, 0, 0};
    exp_wire = '{8'hFF, 8'hED, 8'h02};
    applyStimulus(1'b1, 1'b0, 3'd0);
    repeat (5) @(negedge clock);
    checkOutput("busy during FF", bus.busy, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b1, 3'd2);
    endTxn("latest_wins", 2, 0);

    $display("[TB] Reset during bit 4 of SEND");
    beginTxn();
    dev_plan = '{4};
    applyStimulus(1'b0, 1'b1, 3'b110);
    begin
      int n = 0;
      while (dev_bit_count != 5 && n < 2000) begin @(negedge clock); n++; end
      checkOutput("reached bit 4", n < 2000, 1'b1);
    end
    repeat (4) @(negedge clock);
    checkOutput("busy before reset", bus.busy, 1'b1);
    checkOutput("ED bit4 drives data low", bus.device_data_oe, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset clock_oe", bus.device_clock_oe, 1'b0);
    checkOutput("async reset data_oe", bus.device_data_oe, 1'b0);
    checkOutput("async reset busy", bus.busy, 1'b0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    repeat (250) @(negedge clock);
    checkOutput("post reset busy", bus.busy, 1'b0);
    checkOutput("post reset no restart", start_count - base_start, 1);
    checkOutput("post reset no pulses", (done_count - base_done) + (err_count - base_err), 0);
    dev_plan.delete();

    $display("[TB] Randomized commands");
    for (int t = 0; t < 20; t++) begin
      beginTxn();
      is_led = 1'($urandom_range(0, 1));
      val    = 3'($urandom_range(0, 7));
      planRandom(is_led, val, ok);
      applyStimulus(!is_led, is_led, val);
      endTxn(is_led ? "rand_led" : "rand_rst", ok ? 1 : 0, ok ? 0 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
